imem_loader: RTL

Boot-time program loader that writes into the instruction memory the CPU fetches from. It accepts an 8-bit byte stream over a valid/ready handshake and packs pairs of bytes into 16-bit instruction words, high byte first. Each word is written to successive even byte addresses starting at a programmed base. While a load is in progress it holds the pipeline in reset through `cpu_hold`, and releases it when the last word has been written.

---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
//
// Boot-time program loader for the instruction memory. A byte stream arriving
// over a valid/ready handshake is packed into 16-bit words (high byte first)
// and written to consecutive even byte addresses starting at a latched base.
// While a load is in progress the CPU is held in reset through cpu_hold.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a 16-bit additive checksum of the written words is kept and
//                reported on `checksum`.
//   undefined -> no accumulator; `checksum` is tied to 16'h0000.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous reset, active-high
//   start       in   load request, sampled only in IDLE
//   base_addr   in   first byte address (bit 0 forced to 0), latched on start
//   word_count  in   number of 16-bit words to load, latched on start
//   in_valid    in   byte-stream valid
//   in_data     in   byte-stream data
//   in_ready    out  a byte is accepted this cycle if in_valid is high
//   mem_we      out  instruction-memory write strobe, one cycle per word
//   mem_addr    out  write byte address (even)
//   mem_wdata   out  write data {high byte, low byte}
//   cpu_hold    out  high while a load is in progress (CPU reset)
//   busy        out  high in every state except IDLE and DONE
//   done        out  one-cycle pulse when a load completes
//   checksum    out  additive checksum of written words (see macro above)

module imem_loader #(
    parameter int ADDR_WIDTH  = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [15:0]            mem_wdata,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            checksum
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [ADDR_WIDTH-1:0]  addr_reg;       // address of the word being assembled
    logic [COUNT_WIDTH-1:0] count_reg;      // words still to be written
    logic [7:0]             hi_reg;         // captured high byte
    logic [ADDR_WIDTH-1:0]  mem_addr_reg;
    logic [15:0]            mem_wdata_reg;

    logic                   start_load;     // accepted start with a non-zero count

    assign start_load = (state_reg == S_IDLE) && start && (word_count != '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (word_count != '0) ? S_HI : S_DONE;
                end
            end
            S_HI: begin
                if (in_valid) begin
                    state_next = S_LO;
                end
            end
            S_LO: begin
                if (in_valid) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // Remaining count reaches zero after this write.
                state_next = (count_reg == COUNT_WIDTH'(1)) ? S_DONE : S_HI;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // mem_addr/mem_wdata are loaded on the low-byte handshake so they are
    // valid throughout WRITE and hold their last value everywhere else.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg      <= '0;
            count_reg     <= '0;
            hi_reg        <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_load) begin
                        addr_reg  <= base_addr & ~ADDR_WIDTH'(1);
                        count_reg <= word_count;
                    end
                end
                S_HI: begin
                    if (in_valid) begin
                        hi_reg <= in_data;
                    end
                end
                S_LO: begin
                    if (in_valid) begin
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= {hi_reg, in_data};
                    end
                end
                S_WRITE: begin
                    // Address wraps modulo 2^ADDR_WIDTH by natural overflow.
                    count_reg <= count_reg - COUNT_WIDTH'(1);
                    addr_reg  <= addr_reg + ADDR_WIDTH'(2);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Cleared on an accepted load, accumulates each word during its WRITE
    // cycle, and otherwise holds so the final sum stays visible after DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum_reg <= '0;
        end else if (start_load) begin
            checksum_reg <= '0;
        end else if (state_reg == S_WRITE) begin
            checksum_reg <= checksum_reg + mem_wdata_reg;
        end
    end

    assign checksum = checksum_reg;
`else
    assign checksum = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from the registered state only
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == S_HI) || (state_reg == S_LO);
    assign mem_we    = (state_reg == S_WRITE);
    assign busy      = in_ready || mem_we;
    assign cpu_hold  = busy;
    assign done      = (state_reg == S_DONE);
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule
